// File: rtl/ntt_pkg.sv
// ntt_pkg: shared constants, FSM state type and elaboration-time helpers for
// the closely-coupled NTT accelerator.
//   Q          - coefficient modulus (7681)
//   N_MAX      - longest transform (64 coefficients in 32 registers)
//   OMEGA      - smallest element of multiplicative order 64 mod Q
//   bit_rev    - reverse the low 'bits' bits of a 6-bit index
//   twiddle_rom- entry k holds OMEGA^brv6(k) mod Q
package ntt_pkg;

   localparam int Q          = 7681;
   localparam int N_MAX      = 64;
   localparam int NUM_REGS   = 32;
   localparam int DATA_WIDTH = 32;
   localparam int COEF_W     = 16;
   localparam int RES_W      = 13;
   localparam int OMEGA      = 330;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } ntt_state_e;

   function automatic logic [5:0] bit_rev(input logic [5:0] v, input logic [2:0] bits);
      logic [5:0] src;
      logic [5:0] r;
      src = v;
      r   = 6'd0;
      for (int i = 0; i < 6; i++) begin
         if (3'(i) < bits) begin
            r   = {r[4:0], src[0]};
            src = src >> 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   function automatic logic [RES_W-1:0] mod_pow(input int base, input int e);
      longint acc;
      acc = 64'sd1;
      for (int i = 0; i < N_MAX; i++) begin
         if (i < e) begin
            acc = (acc * longint'(base)) % longint'(Q);
         end else begin
            acc = acc;
         end
      end
      return RES_W'(acc);
   endfunction

   // Group g of any stage uses entry 2g, i.e. exponent brv5(g); the N=32 mode
   // only reaches even exponents, which is the same as stepping by OMEGA^2.
   function automatic logic [RES_W-1:0] twiddle_rom(input logic [5:0] k);
      return mod_pow(OMEGA, int'(bit_rev(k, 3'd6)));
   endfunction

endpackage

// File: rtl/ntt_closely_coupled_top_butterfly.sv
// ntt_butterfly: combinational Cooley-Tukey butterfly mod Q.
//   a_i, b_i  - raw 16-bit coefficients (any value, reduced here)
//   zeta_i    - twiddle, already in [0, Q)
//   a_o, b_o  - a + zeta*b and a - zeta*b, both fully reduced to [0, Q)
module ntt_butterfly
   import ntt_pkg::*;
(
   input  logic [COEF_W-1:0] a_i,
   input  logic [COEF_W-1:0] b_i,
   input  logic [RES_W-1:0]  zeta_i,
   output logic [RES_W-1:0]  a_o,
   output logic [RES_W-1:0]  b_o
);

   localparam logic [RES_W-1:0] Q_RED     = RES_W'(Q);
   // floor(2^26 / Q); leaves a remainder below 2Q for any input under 2^26
   localparam logic [13:0]      BARRETT_M = 14'd8736;

   function automatic logic [RES_W-1:0] barrett_reduce(input logic [25:0] x);
      logic [39:0]      prod;
      logic [13:0]      qhat;
      logic [13:0]      rem;
      logic [RES_W-1:0] res;
      prod = 40'(x) * 40'(BARRETT_M);
      qhat = 14'(prod >> 26);
      rem  = 14'(27'(x) - 27'(qhat) * 27'(Q_RED));
      if (rem >= 14'(Q_RED)) begin
         res = RES_W'(rem - 14'(Q_RED));
      end else begin
         res = RES_W'(rem);
      end
      return res;
   endfunction

   logic [RES_W-1:0] a_red_s;
   logic [RES_W-1:0] b_red_s;
   logic [RES_W-1:0] t_s;
   logic [13:0]      sum_s;

   // Reduce operands, multiply by the twiddle, then modular add/sub.
   always_comb begin
      a_red_s = barrett_reduce(26'(a_i));
      b_red_s = barrett_reduce(26'(b_i));
      t_s     = barrett_reduce(26'(b_red_s) * 26'(zeta_i));
      sum_s   = 14'(a_red_s) + 14'(t_s);
      if (sum_s >= 14'(Q_RED)) begin
         a_o = RES_W'(sum_s - 14'(Q_RED));
      end else begin
         a_o = RES_W'(sum_s);
      end
      if (a_red_s >= t_s) begin
         b_o = a_red_s - t_s;
      end else begin
         b_o = RES_W'(14'(a_red_s) + 14'(Q_RED) - 14'(t_s));
      end
   end

endmodule

// File: rtl/ntt_closely_coupled_top.sv
// ntt_closely_coupled_top: in-place forward NTT on the PQ register file,
// one butterfly per cycle, natural-order input, bit-reversed output.
//   clk, rst     - clock, synchronous active-high reset
//   ntt_start    - start request, acted on at its rising edge in IDLE
//   param_n      - 0: N=64 (regs 0-31), 1: N=32 (regs 0-15); sampled at start
//   rdata_pq_i   - register file contents, coefficient 2r in reg r [15:0]
//   wdata_pq_o   - per-register write data (0 where not written)
//   we_pq_o      - per-register write enable, at most two bits per cycle
//   ntt_done_o   - one-cycle pulse after the final butterfly
module ntt_closely_coupled_top
   import ntt_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ntt_start,
   input  logic                  param_n,
   input  logic [DATA_WIDTH-1:0] rdata_pq_i [NUM_REGS],
   output logic [DATA_WIDTH-1:0] wdata_pq_o [NUM_REGS],
   output logic [NUM_REGS-1:0]   we_pq_o,
   output logic                  ntt_done_o
);

   ntt_state_e state_q, state_d;
   logic       start_q, start_d;
   logic       n32_q, n32_d;
   logic [2:0] stage_q, stage_d;    // log2 of the butterfly half-distance
   logic [4:0] bf_q, bf_d;          // butterfly index within the stage
   logic       done_q, done_d;

   logic [RES_W-1:0] tw_rom [N_MAX];

   for (genvar k = 0; k < N_MAX; k++) begin : g_tw
      localparam logic [RES_W-1:0] TW = twiddle_rom(6'(k));
      assign tw_rom[k] = TW;
   end

   logic             start_edge_s;
   logic             last_bf_s;
   logic [5:0]       mask_s;
   logic [5:0]       idx_a_s;
   logic [5:0]       idx_b_s;
   logic [4:0]       grp_s;
   logic [4:0]       reg_a_s;
   logic [4:0]       reg_b_s;
   logic [COEF_W-1:0] a_raw_s;
   logic [COEF_W-1:0] b_raw_s;
   logic [RES_W-1:0]  zeta_s;
   logic [RES_W-1:0]  a_res_s;
   logic [RES_W-1:0]  b_res_s;

   // Next-state logic for the sequencer and its counters.
   always_comb begin
      start_edge_s = ntt_start & ~start_q;
      last_bf_s    = (bf_q == (n32_q ? 5'd15 : 5'd31));
      state_d      = state_q;
      start_d      = ntt_start;
      n32_d        = n32_q;
      stage_d      = stage_q;
      bf_d         = bf_q;
      case (state_q)
         ST_IDLE: begin
            if (start_edge_s) begin
               state_d = ST_RUN;
               n32_d   = param_n;
               stage_d = param_n ? 3'd4 : 3'd5;
               bf_d    = 5'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (last_bf_s) begin
               bf_d = 5'd0;
               if (stage_q == 3'd0) begin
                  state_d = ST_DONE;
               end else begin
                  stage_d = stage_q - 3'd1;
               end
            end else begin
               bf_d = bf_q + 5'd1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      done_d = (state_d == ST_DONE);
   end

   // Sequencer state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         n32_q   <= 1'b0;
         stage_q <= 3'd0;
         bf_q    <= 5'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         n32_q   <= n32_d;
         stage_q <= stage_d;
         bf_q    <= bf_d;
         done_q  <= done_d;
      end
   end

   // Pair addressing: insert a zero at bit 'stage' of the butterfly index.
   always_comb begin
      mask_s  = (6'd1 << stage_q) - 6'd1;
      idx_a_s = (({1'b0, bf_q} & ~mask_s) << 1) | ({1'b0, bf_q} & mask_s);
      idx_b_s = idx_a_s | (6'd1 << stage_q);
      grp_s   = bf_q >> stage_q;
      zeta_s  = tw_rom[{grp_s, 1'b0}];
      reg_a_s = idx_a_s[5:1];
      reg_b_s = idx_b_s[5:1];
      a_raw_s = idx_a_s[0] ? rdata_pq_i[reg_a_s][31:16] : rdata_pq_i[reg_a_s][15:0];
      b_raw_s = idx_b_s[0] ? rdata_pq_i[reg_b_s][31:16] : rdata_pq_i[reg_b_s][15:0];
   end

   ntt_butterfly u_bf (
      .a_i    (a_raw_s),
      .b_i    (b_raw_s),
      .zeta_i (zeta_s),
      .a_o    (a_res_s),
      .b_o    (b_res_s)
   );

   // Write-back: the untouched halfword is copied; len=1 packs both results.
   always_comb begin
      for (int r = 0; r < NUM_REGS; r++) begin
         wdata_pq_o[r] = 32'd0;
      end
      we_pq_o = {NUM_REGS{1'b0}};
      if ((state_q == ST_RUN) && !rst) begin
         if (stage_q == 3'd0) begin
            we_pq_o[reg_a_s]    = 1'b1;
            wdata_pq_o[reg_a_s] = {3'd0, b_res_s, 3'd0, a_res_s};
         end else begin
            we_pq_o[reg_a_s]    = 1'b1;
            we_pq_o[reg_b_s]    = 1'b1;
            wdata_pq_o[reg_a_s] = idx_a_s[0] ? {3'd0, a_res_s, rdata_pq_i[reg_a_s][15:0]}
                                             : {rdata_pq_i[reg_a_s][31:16], 3'd0, a_res_s};
            wdata_pq_o[reg_b_s] = idx_b_s[0] ? {3'd0, b_res_s, rdata_pq_i[reg_b_s][15:0]}
                                             : {rdata_pq_i[reg_b_s][31:16], 3'd0, b_res_s};
         end
      end else begin
         we_pq_o = {NUM_REGS{1'b0}};
      end
   end

   assign ntt_done_o = done_q;

endmodule

// File: tb/tb_ntt_closely_coupled_top.sv
// Testbench for ntt_closely_coupled_top. Holds the register file, compares
// results against a direct DFT evaluation in bit-reversed output order.
module tb_ntt_closely_coupled_top;

   localparam int Q = 7681;

   logic        clk = 1'b0;
   logic        rst;
   logic        ntt_start;
   logic        param_n;
   logic [31:0] rf [32];
   logic [31:0] wdata [32];
   logic [31:0] we;
   logic        done;
   logic [31:0] load_val [32];
   logic        load_en;
   logic [31:0] start_rf [32];
   logic [31:0] exp_rf [32];
   int          checks = 0;
   int          errors = 0;
   int          omega;

   typedef struct {
      int          pattern;
      logic        pn;
      int          glitch_k;
      int          exp_lat;
      logic        chk_reg0;
      logic [31:0] exp_reg0;
   } vec_t;

   vec_t vecs [8];

   ntt_closely_coupled_top dut (
      .clk        (clk),
      .rst        (rst),
      .ntt_start  (ntt_start),
      .param_n    (param_n),
      .rdata_pq_i (rf),
      .wdata_pq_o (wdata),
      .we_pq_o    (we),
      .ntt_done_o (done)
   );

   always #5 clk = ~clk;

   // Register file: bulk load from the bench, otherwise per-register writes.
   always @(posedge clk) begin
      if (load_en) begin
         for (int r = 0; r < 32; r++) rf[r] <= load_val[r];
      end else begin
         for (int r = 0; r < 32; r++) if (we[r]) rf[r] <= wdata[r];
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int mpow(input int b, input int e);
      longint acc;
      acc = 1;
      for (int i = 0; i < e; i++) acc = (acc * longint'(b)) % longint'(Q);
      return int'(acc);
   endfunction

   function automatic int brv(input int v, input int bits);
      int r;
      r = 0;
      for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
      return r;
   endfunction

   // X[p] = sum_j x_j * w^(j*brv(p)), w an N-th root of unity; upper regs kept.
   task automatic compute_model(input logic pn);
      int     n, lg, w;
      int     x [64];
      int     wp [64];
      longint acc;
      n  = pn ? 32 : 64;
      lg = pn ? 5 : 6;
      w  = pn ? mpow(omega, 2) : omega;
      for (int j = 0; j < n; j++)
         x[j] = int'((start_rf[j/2] >> (16 * (j % 2))) & 32'h0000FFFF) % Q;
      for (int e = 0; e < n; e++) wp[e] = mpow(w, e);
      for (int r = 0; r < 32; r++) exp_rf[r] = start_rf[r];
      for (int p = 0; p < n; p++) begin
         acc = 0;
         for (int j = 0; j < n; j++)
            acc = (acc + longint'(x[j]) * longint'(wp[(j * brv(p, lg)) % n])) % longint'(Q);
         if (p % 2 == 0) exp_rf[p/2][15:0]  = 16'(acc);
         else            exp_rf[p/2][31:16] = 16'(acc);
      end
   endtask

   task automatic load_rf();
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int done_k, dones, we_cyc, over2, bad_range;
      for (int r = 0; r < 32; r++) begin
         case (v.pattern)
            0:       load_val[r] = 32'h0000_0000;
            1:       load_val[r] = (r == 0) ? 32'h0000_0001 : 32'h0000_0000;
            2:       load_val[r] = 32'h0001_0001;
            3:       load_val[r] = {16'(2 * r + 1), 16'(2 * r)};
            4:       load_val[r] = (r >= 16) ? 32'hABCD_1234 : ((r == 0) ? 32'h0000_0001 : 32'h0000_0000);
            default: load_val[r] = $urandom();
         endcase
         start_rf[r] = load_val[r];
      end
      compute_model(v.pn);
      load_rf();
      param_n   = v.pn;
      ntt_start = 1'b1;
      done_k = -1; dones = 0; we_cyc = 0; over2 = 0;
      for (int k = 1; k <= 260; k++) begin
         @(negedge clk);
         if (done) begin
            dones++;
            if (done_k < 0) done_k = k;
         end
         if (we != 32'd0) we_cyc++;
         if ($countones(we) > 2) over2++;
         param_n   = ~v.pn;
         ntt_start = (v.glitch_k != 0) && (k == v.glitch_k);
      end
      check($sformatf("v%0d_done_cycle", idx), 64'(done_k), 64'(v.exp_lat));
      check($sformatf("v%0d_done_count", idx), 64'(dones), 64'd1);
      check($sformatf("v%0d_write_cycles", idx), 64'(we_cyc), 64'(v.exp_lat - 1));
      check($sformatf("v%0d_we_popcount", idx), 64'(over2), 64'd0);
      if (v.chk_reg0) check($sformatf("v%0d_reg0", idx), 64'(rf[0]), 64'(v.exp_reg0));
      if (v.pattern == 4) check($sformatf("v%0d_reg16", idx), 64'(rf[16]), 64'h0000_0000_ABCD_1234);
      bad_range = 0;
      for (int r = 0; r < (v.pn ? 16 : 32); r++)
         if ((rf[r][31:29] != 3'd0) || (rf[r][15:13] != 3'd0)) bad_range++;
      check($sformatf("v%0d_range", idx), 64'(bad_range), 64'd0);
      for (int r = 0; r < 32; r++)
         check($sformatf("v%0d_reg%0d", idx, r), 64'(rf[r]), 64'(exp_rf[r]));
   endtask

   initial begin
      int dones, we_cyc, nz;
      vecs[0] = '{0, 1'b0, 0,   193, 1'b1, 32'h0000_0000};
      vecs[1] = '{1, 1'b0, 0,   193, 1'b1, 32'h0001_0001};
      vecs[2] = '{2, 1'b0, 0,   193, 1'b1, 32'h0000_0040};
      vecs[3] = '{3, 1'b0, 0,   193, 1'b1, 32'h1DE1_07E0};
      vecs[4] = '{4, 1'b1, 0,    81, 1'b1, 32'h0001_0001};
      vecs[5] = '{5, 1'b0, 40,  193, 1'b0, 32'h0000_0000};
      vecs[6] = '{5, 1'b1, 81,   81, 1'b0, 32'h0000_0000};
      vecs[7] = '{5, 1'b0, 0,   193, 1'b0, 32'h0000_0000};

      omega = 0;
      for (int w = 2; (w < Q) && (omega == 0); w++)
         if ((mpow(w, 64) == 1) && (mpow(w, 32) != 1)) omega = w;

      // Reset with start already high; register file cleared meanwhile.
      rst = 1'b1; ntt_start = 1'b1; param_n = 1'b0; load_en = 1'b1;
      for (int r = 0; r < 32; r++) load_val[r] = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_we", 64'(we), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      nz = 0;
      for (int r = 0; r < 32; r++) if (wdata[r] !== 32'd0) nz++;
      check("reset_wdata", 64'(nz), 64'd0);
      load_en = 1'b0;
      rst = 1'b0;

      dones = 0; we_cyc = 0;
      for (int k = 1; k <= 400; k++) begin
         @(negedge clk);
         if (done) dones++;
         if (we != 32'd0) we_cyc++;
      end
      check("held_start_dones", 64'(dones), 64'd1);
      check("held_start_writes", 64'(we_cyc), 64'd192);
      nz = 0;
      for (int r = 0; r < 32; r++) if (rf[r] !== 32'd0) nz++;
      check("held_start_zero_rf", 64'(nz), 64'd0);
      ntt_start = 1'b0;
      @(negedge clk);

      // Abort with reset 50 cycles into a run.
      for (int r = 0; r < 32; r++) load_val[r] = $urandom();
      load_rf();
      ntt_start = 1'b1;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         ntt_start = 1'b0;
      end
      check("abort_pre_we_active", 64'(we != 32'd0), 64'd1);
      rst = 1'b1;
      #1;
      check("abort_we_forced", 64'(we), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      dones = 0; we_cyc = 0;
      for (int k = 1; k <= 250; k++) begin
         @(negedge clk);
         if (done) dones++;
         if (we != 32'd0) we_cyc++;
      end
      check("abort_no_done", 64'(dones), 64'd0);
      check("abort_idle_no_writes", 64'(we_cyc), 64'd0);

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
